// File: rtl/rv_decode_exec.sv
// rv_decode_exec: RV32I decode/execute slice.
// Decodes one instruction, builds its immediate, runs the ALU, and registers
// the result and control signals with one cycle of latency.
// Optional: define RV_DECODE_SHIFT_EN to include the shifter. Without it, every
// shift encoding decodes as illegal.
module rv_decode_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic            out_valid,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            branch_taken,
  output logic            alu_zero,
  output logic            alu_negative,
  output logic            illegal
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } aluOp_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  aluOp_t          decOp;
  logic            decSrc;
  logic            decRegWrite;
  logic            decMemWrite;
  logic            decMemToReg;
  logic            decBranch;
  logic            decIllegal;
  logic [XLEN-1:0] decImm;
  logic [XLEN-1:0] operand2;
  logic [XLEN-1:0] aluRes;
`ifdef RV_DECODE_SHIFT_EN
  logic [4:0]      shamt;
`endif

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // Immediate generation, selected by opcode and sign-extended from instr[31].
  always_comb begin
    decImm = '0;
    case (opcode)
      OPC_IMM, OPC_LOAD: decImm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:         decImm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:        decImm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0};
      default:           decImm = '0;
    endcase
  end

  // Instruction decode; an illegal encoding is forced to a harmless ADD with no side effects.
  always_comb begin
    decOp       = OP_ADD;
    decSrc      = 1'b0;
    decRegWrite = 1'b0;
    decMemWrite = 1'b0;
    decMemToReg = 1'b0;
    decBranch   = 1'b0;
    decIllegal  = 1'b0;
    case (opcode)
      OPC_R: begin
        decSrc      = 1'b1;
        decRegWrite = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     decOp = OP_ADD;
            else if (funct7 == F7_ALT) decOp = OP_SUB;
            else                       decIllegal = 1'b1;
          end
`ifdef RV_DECODE_SHIFT_EN
          3'b001: begin
            if (funct7 == F7_BASE) decOp = OP_SLL;
            else                   decIllegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     decOp = OP_SRL;
            else if (funct7 == F7_ALT) decOp = OP_SRA;
            else                       decIllegal = 1'b1;
          end
`endif
          3'b010: begin
            decOp = OP_SLT;
            if (funct7 != F7_BASE) decIllegal = 1'b1;
          end
          3'b011: begin
            decOp = OP_SLTU;
            if (funct7 != F7_BASE) decIllegal = 1'b1;
          end
          3'b100: begin
            decOp = OP_XOR;
            if (funct7 != F7_BASE) decIllegal = 1'b1;
          end
          3'b110: begin
            decOp = OP_OR;
            if (funct7 != F7_BASE) decIllegal = 1'b1;
          end
          3'b111: begin
            decOp = OP_AND;
            if (funct7 != F7_BASE) decIllegal = 1'b1;
          end
          default: decIllegal = 1'b1;
        endcase
      end
      OPC_IMM: begin
        decRegWrite = 1'b1;
        case (funct3)
          3'b000: decOp = OP_ADD;
          3'b010: decOp = OP_SLT;
          3'b011: decOp = OP_SLTU;
          3'b100: decOp = OP_XOR;
          3'b110: decOp = OP_OR;
          3'b111: decOp = OP_AND;
`ifdef RV_DECODE_SHIFT_EN
          3'b001: begin
            if (funct7 == F7_BASE) decOp = OP_SLL;
            else                   decIllegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     decOp = OP_SRL;
            else if (funct7 == F7_ALT) decOp = OP_SRA;
            else                       decIllegal = 1'b1;
          end
`endif
          default: decIllegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          decRegWrite = 1'b1;
          decMemToReg = 1'b1;
        end else begin
          decIllegal = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) decMemWrite = 1'b1;
        else                  decIllegal  = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000) begin
          decOp     = OP_SUB;
          decSrc    = 1'b1;
          decBranch = 1'b1;
        end else begin
          decIllegal = 1'b1;
        end
      end
      default: decIllegal = 1'b1;
    endcase
    if (decIllegal) begin
      decOp       = OP_ADD;
      decSrc      = 1'b0;
      decRegWrite = 1'b0;
      decMemWrite = 1'b0;
      decMemToReg = 1'b0;
      decBranch   = 1'b0;
    end
  end

  assign operand2 = decSrc ? rs2_data : decImm;
`ifdef RV_DECODE_SHIFT_EN
  assign shamt = operand2[4:0];
`endif

  // 32-bit ALU; arithmetic wraps, comparisons produce 0 or 1.
  always_comb begin
    aluRes = '0;
    case (decOp)
      OP_AND:  aluRes = rs1_data & operand2;
      OP_OR:   aluRes = rs1_data | operand2;
      OP_ADD:  aluRes = rs1_data + operand2;
      OP_XOR:  aluRes = rs1_data ^ operand2;
      OP_SUB:  aluRes = rs1_data - operand2;
`ifdef RV_DECODE_SHIFT_EN
      OP_SLL:  aluRes = rs1_data << shamt;
      OP_SRL:  aluRes = rs1_data >> shamt;
      OP_SRA:  aluRes = $unsigned($signed(rs1_data) >>> shamt);
`endif
      OP_SLT:  aluRes[0] = $signed(rs1_data) < $signed(operand2);
      OP_SLTU: aluRes[0] = rs1_data < operand2;
      default: aluRes = '0;
    endcase
  end

  // Output register: idle cycles clear the strobes and hold the datapath values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      rd_addr      <= '0;
      alu_result   <= '0;
      store_data   <= '0;
      imm          <= '0;
      alu_op       <= '0;
      alu_src      <= 1'b0;
      reg_write    <= 1'b0;
      mem_write    <= 1'b0;
      mem_to_reg   <= 1'b0;
      branch_taken <= 1'b0;
      alu_zero     <= 1'b0;
      alu_negative <= 1'b0;
      illegal      <= 1'b0;
    end else if (in_valid) begin
      out_valid    <= 1'b1;
      rd_addr      <= instr[11:7];
      alu_result   <= aluRes;
      store_data   <= rs2_data;
      imm          <= decImm;
      alu_op       <= decOp;
      alu_src      <= decSrc;
      reg_write    <= decRegWrite;
      mem_write    <= decMemWrite;
      mem_to_reg   <= decMemToReg;
      branch_taken <= decBranch && (aluRes == '0);
      alu_zero     <= (aluRes == '0);
      alu_negative <= aluRes[XLEN-1];
      illegal      <= decIllegal;
    end else begin
      out_valid    <= 1'b0;
      reg_write    <= 1'b0;
      mem_write    <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_decode_exec.sv
// Testbench for rv_decode_exec: directed vectors feed a scoreboard queue,
// a monitor on the falling edge pops and compares every registered output.
module tb_rv_decode_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        out_valid;
  logic [4:0]  rd_addr;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        reg_write;
  logic        mem_write;
  logic        mem_to_reg;
  logic        branch_taken;
  logic        alu_zero;
  logic        alu_negative;
  logic        illegal;

  always #5 clk = ~clk;

  rv_decode_exec #(.XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .instr        (instr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .out_valid    (out_valid),
    .rd_addr      (rd_addr),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .imm          (imm),
    .alu_op       (alu_op),
    .alu_src      (alu_src),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .branch_taken (branch_taken),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .illegal      (illegal)
  );

  typedef struct {
    int          tag;
    int          due;
    logic        ov;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] sd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        src;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        br;
    logic        z;
    logic        n;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   nChecks    = 0;
  int   nFail      = 0;
  int   cycleCount = 0;

  always @(posedge clk) cycleCount++;

  task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL vec%0d %s: got %h, expected %h", tag, nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int tag, input logic ov, input logic [4:0] rd,
                              input logic [31:0] res, input logic [31:0] sd, input logic [31:0] im,
                              input logic [3:0] op, input logic src, input logic rw, input logic mw,
                              input logic m2r, input logic br, input logic z, input logic n,
                              input logic ill);
    exp_t e;
    e.tag = tag; e.due = 0; e.ov = ov; e.rd = rd; e.res = res; e.sd = sd; e.imm = im;
    e.op = op; e.src = src; e.rw = rw; e.mw = mw; e.m2r = m2r; e.br = br; e.z = z;
    e.n = n; e.ill = ill;
    return e;
  endfunction

  // Apply one vector just after a rising edge; its result is due after the next edge.
  task automatic drive(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ra1, input logic [4:0] ra2, input exp_t e);
    @(posedge clk);
    #1;
    reset    = rst;
    in_valid = v;
    instr    = ins;
    rs1_data = a;
    rs2_data = b;
    e.due    = cycleCount + 1;
    sb.push_back(e);
    #1;
    chk(e.tag, "rs1_addr", 32'(rs1_addr), 32'(ra1));
    chk(e.tag, "rs2_addr", 32'(rs2_addr), 32'(ra2));
  endtask

  // Monitor: compare every registered output against the entry due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due == cycleCount) begin
        e = sb.pop_front();
        chk(e.tag, "out_valid",    32'(out_valid),    32'(e.ov));
        chk(e.tag, "rd_addr",      32'(rd_addr),      32'(e.rd));
        chk(e.tag, "alu_result",   alu_result,        e.res);
        chk(e.tag, "store_data",   store_data,        e.sd);
        chk(e.tag, "imm",          imm,               e.imm);
        chk(e.tag, "alu_op",       32'(alu_op),       32'(e.op));
        chk(e.tag, "alu_src",      32'(alu_src),      32'(e.src));
        chk(e.tag, "reg_write",    32'(reg_write),    32'(e.rw));
        chk(e.tag, "mem_write",    32'(mem_write),    32'(e.mw));
        chk(e.tag, "mem_to_reg",   32'(mem_to_reg),   32'(e.m2r));
        chk(e.tag, "branch_taken", 32'(branch_taken), 32'(e.br));
        chk(e.tag, "alu_zero",     32'(alu_zero),     32'(e.z));
        chk(e.tag, "alu_negative", 32'(alu_negative), 32'(e.n));
        chk(e.tag, "illegal",      32'(illegal),      32'(e.ill));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'h00500093;
    rs1_data = '0;
    rs2_data = '0;

    //    rst  v   instr         rs1           rs2           ra1 ra2  expected(tag ov rd res sd imm op src rw mw m2r br z n ill)
    drive(1, 1, 32'h00500093, 32'h0,        32'h0,        0,  5,  mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 1, 32'h00500093, 32'h0,        32'h0,        0,  5,  mk(1, 0, 0, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    // ADDI x1,x0,5
    drive(0, 1, 32'h00500093, 32'h0,        32'h11,       0,  5,  mk(2, 1, 1, 32'h5, 32'h11, 32'h5, 4'b0010, 0, 1, 0, 0, 0, 0, 0, 0));
    // SUB x2,x1,x2: 3 - 5
    drive(0, 1, 32'h40208133, 32'h3,        32'h5,        1,  2,  mk(3, 1, 2, 32'hFFFFFFFE, 32'h5, 32'h0, 4'b0110, 1, 1, 0, 0, 0, 0, 1, 0));
    // BEQ x1,x2,-8 taken and not taken
    drive(0, 1, 32'hFE208CE3, 32'h7,        32'h7,        1,  2,  mk(4, 1, 25, 32'h0, 32'h7, 32'hFFFFFFF8, 4'b0110, 1, 0, 0, 0, 1, 1, 0, 0));
    drive(0, 1, 32'hFE208CE3, 32'h7,        32'h8,        1,  2,  mk(5, 1, 25, 32'hFFFFFFFF, 32'h8, 32'hFFFFFFF8, 4'b0110, 1, 0, 0, 0, 0, 0, 1, 0));
    // SW x2,12(x1)
    drive(0, 1, 32'h0020A623, 32'h100,      32'hAB,       1,  2,  mk(6, 1, 12, 32'h10C, 32'hAB, 32'hC, 4'b0010, 0, 0, 1, 0, 0, 0, 0, 0));
    // LW x3,4(x1)
    drive(0, 1, 32'h0040A183, 32'h100,      32'h55,       1,  4,  mk(7, 1, 3, 32'h104, 32'h55, 32'h4, 4'b0010, 0, 1, 0, 1, 0, 0, 0, 0));
    // idle: strobes drop, mem_to_reg and datapath hold
    drive(0, 0, 32'hFFFFFFFF, 32'h999,      32'h777,      31, 31, mk(8, 0, 3, 32'h104, 32'h55, 32'h4, 4'b0010, 0, 0, 0, 1, 0, 0, 0, 0));
    // all-ones word is illegal; result is rs1 + 0
    drive(0, 1, 32'hFFFFFFFF, 32'h20,       32'h30,       31, 31, mk(9, 1, 31, 32'h20, 32'h30, 32'h0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1));
    // idle after illegal: illegal clears, alu_result holds
    drive(0, 0, 32'h00500093, 32'h999,      32'h1,        0,  5,  mk(10, 0, 31, 32'h20, 32'h30, 32'h0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0));
    // SLT x4,x1,x2: -1 < 1 signed
    drive(0, 1, 32'h0020A233, 32'hFFFFFFFF, 32'h1,        1,  2,  mk(11, 1, 4, 32'h1, 32'h1, 32'h0, 4'b1000, 1, 1, 0, 0, 0, 0, 0, 0));
    // SLTU x4,x1,x2: 0xFFFFFFFF < 1 unsigned is false
    drive(0, 1, 32'h0020B233, 32'hFFFFFFFF, 32'h1,        1,  2,  mk(12, 1, 4, 32'h0, 32'h1, 32'h0, 4'b1001, 1, 1, 0, 0, 0, 1, 0, 0));
    // XORI x5,x1,-1
    drive(0, 1, 32'hFFF0C293, 32'h0F0F0F0F, 32'h0,        1,  31, mk(13, 1, 5, 32'hF0F0F0F0, 32'h0, 32'hFFFFFFFF, 4'b0011, 0, 1, 0, 0, 0, 0, 1, 0));
    // SRAI x6,x1,4
`ifdef RV_DECODE_SHIFT_EN
    drive(0, 1, 32'h4040D313, 32'h80000000, 32'h0,        1,  4,  mk(14, 1, 6, 32'hF8000000, 32'h0, 32'h404, 4'b0111, 0, 1, 0, 0, 0, 0, 1, 0));
`else
    drive(0, 1, 32'h4040D313, 32'h80000000, 32'h0,        1,  4,  mk(14, 1, 6, 32'h80000404, 32'h0, 32'h404, 4'b0010, 0, 0, 0, 0, 0, 0, 1, 1));
`endif
    // SLLI with funct7=0100000 is illegal in every build
    drive(0, 1, 32'h40409313, 32'h1,        32'h0,        1,  4,  mk(15, 1, 6, 32'h405, 32'h0, 32'h404, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1));
    // R-type with funct7=0000001 (M extension) is illegal
    drive(0, 1, 32'h022083B3, 32'h5,        32'h9,        1,  2,  mk(16, 1, 7, 32'h5, 32'h9, 32'h0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 1));

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    nChecks++;
    if (sb.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d expected responses never checked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
